// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STAT bit positions, serializer states and a divisor helper.
package uart_tx_mmio_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;

  localparam int STAT_OVF   = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_FULL  = 3;
  localparam int STAT_BUSY  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // A zero divisor would stall the bit timer, so it is promoted to one.
  function automatic logic [15:0] div_sanitize(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with head-of-queue output; a push on a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  always_comb begin
    do_pop_s  = pop && (count_q != {CW{1'b0}});
    do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
    wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == {CW{1'b0}});
  assign empty_next = (count_d == {CW{1'b0}});

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, registered load data,
// TX FIFO and a divisor-timed serializer.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [15:0] DIV_RESET  = 16'd4,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovf_q, ovf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;

  logic        push_s, pop_s;
  logic        fifo_full_s, fifo_empty_s, fifo_empty_next_s;
  logic [7:0]  fifo_dout_s;
  logic [31:0] stat_s;
  logic        unused_wdata_s;

  assign unused_wdata_s = ^wdata[31:16];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .din        (wdata[7:0]),
    .dout       (fifo_dout_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .empty_next (fifo_empty_next_s)
  );

  always_comb begin
    push_s = write && (addr == REG_DATA);
    pop_s  = !fifo_empty_s &&
             ((state_q == ST_IDLE) || ((state_q == ST_STOP) && (cnt_q == 16'd0)));

    stat_s             = 32'd0;
    stat_s[STAT_OVF]   = ovf_q;
    stat_s[STAT_EMPTY] = fifo_empty_s;
    stat_s[STAT_FULL]  = fifo_full_s;
    stat_s[STAT_BUSY]  = (state_q != ST_IDLE);

    // Load data is built from pre-write state so a same-cycle store is invisible.
    rdata_d = rdata_q;
    if (read) begin
      case (addr)
        REG_STAT: rdata_d = stat_s;
        REG_DIV:  rdata_d = {16'd0, div_q};
        default:  rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    div_d = div_q;
    ovf_d = ovf_q;
    if (write) begin
      case (addr)
        REG_STAT: ovf_d = wdata[1] ? 1'b0 : ovf_q;
        REG_DIV:  div_d = div_sanitize(wdata[15:0]);
        default:  div_d = div_q;
      endcase
    end else begin
      div_d = div_q;
    end
    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    // Every state lasts div_q clocks; reloads use the divisor current at the boundary.
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_START;
          shift_d = fifo_dout_s;
          cnt_d   = div_q - 16'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          cnt_d     = div_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = div_q - 16'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (pop_s) begin
          state_d = ST_START;
          shift_d = fifo_dout_s;
          cnt_d   = div_q - 16'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
    irq_d = fifo_empty_next_s && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= DIV_RESET;
      cnt_q     <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      ovf_q     <= 1'b0;
      rdata_q   <= 32'd0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign txd   = txd_q;
  assign irq   = irq_q;

endmodule
